ryu_move_ctrl: RTL

//  Per-frame movement/animation sequencer for Ryu. Turns player buttons into a

---
 rtl/ryu_move_ctrl_if.sv | 21 ++
 rtl/ryu_move_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ryu_move_ctrl_if.sv
// ryu_move_ctrl_if: frame tick, player buttons and sprite/position outputs of the Ryu movement sequencer
interface ryu_move_ctrl_if;
  logic       frame_tick;
  logic       left_btn;
  logic       right_btn;
  logic       punch_btn;
  logic       jump_btn;
  logic       down_btn;
  logic [2:0] sprite;
  logic [9:0] RyuX;
  logic [9:0] RyuY;
  logic       busy;
  modport master (
    output frame_tick, left_btn, right_btn, punch_btn, jump_btn, down_btn,
    input  sprite, RyuX, RyuY, busy
  );
  modport slave (
    input  frame_tick, left_btn, right_btn, punch_btn, jump_btn, down_btn,
    output sprite, RyuX, RyuY, busy
  );
endinterface

// File: rtl/ryu_move_ctrl.sv
// ryu_move_ctrl: per-frame Ryu walk/punch/jump sequencer; define RYU_CROUCH_EN to add the crouch state
module ryu_move_ctrl #(
  parameter int X_START         = 100,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 560,
  parameter int GROUND_Y        = 300,
  parameter int WALK_STEP       = 2,
  parameter int JUMP_V0         = 8,
  parameter int GRAVITY         = 1,
  parameter int PUNCH_FRAMES    = 12,
  parameter int COOLDOWN_FRAMES = 6
) (
  input  logic           vga_clk,
  input  logic           reset_n,
  ryu_move_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_PUNCH,
    S_COOL,
`ifdef RYU_CROUCH_EN
    S_JUMP,
    S_CROUCH
`else
    S_JUMP
`endif
  } state_t;

  localparam logic [10:0]        C_X_MIN  = 11'(X_MIN);
  localparam logic [10:0]        C_X_MAX  = 11'(X_MAX);
  localparam logic [10:0]        C_STEP   = 11'(WALK_STEP);
  localparam logic signed [10:0] C_GROUND = 11'(GROUND_Y);
  localparam logic signed [10:0] C_V0     = 11'(JUMP_V0);
  localparam logic signed [10:0] C_GRAV   = 11'(GRAVITY);
  localparam logic [3:0]         C_PUNCH  = 4'(PUNCH_FRAMES - 1);
  localparam logic [3:0]         C_COOL   = 4'(COOLDOWN_FRAMES - 1);

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_sprite, w_sprite_nxt;
  logic [9:0]         r_x, r_y, w_x_nxt, w_y_nxt, w_x_walk, w_y_air;
  logic signed [10:0] r_vy, w_vy_nxt, w_y_calc;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic               r_punch_prev, r_jump_prev;
  logic [10:0]        w_x11, w_x_left, w_x_right;
  logic               w_punch_edge, w_jump_edge, w_land, w_down;

  assign w_jump_edge  = bus.jump_btn & ~r_jump_prev;
  assign w_punch_edge = bus.punch_btn & ~r_punch_prev;
`ifdef RYU_CROUCH_EN
  assign w_down = bus.down_btn;
`else
  assign w_down = 1'b0;
`endif

  // Walking is evaluated one bit wider than the position so neither clamp can wrap.
  assign w_x11     = {1'b0, r_x};
  assign w_x_left  = (w_x11 < C_X_MIN + C_STEP) ? C_X_MIN : w_x11 - C_STEP;
  assign w_x_right = (w_x11 + C_STEP > C_X_MAX) ? C_X_MAX : w_x11 + C_STEP;
  assign w_x_walk  = (bus.left_btn ^ bus.right_btn) ? 10'(bus.left_btn ? w_x_left : w_x_right) : r_x;

  // Airborne height: signed so rising above the top of the screen is detectable.
  assign w_y_calc = $signed({1'b0, r_y}) - r_vy;
  assign w_land   = w_y_calc >= C_GROUND;
  assign w_y_air  = (w_y_calc < 0) ? 10'd0 : 10'(w_y_calc);

  // State register; it only advances on a frame tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else if (bus.frame_tick) r_state <= w_state_nxt;
  end

  // Next state: on the ground a jump beats a punch, which beats crouch.
  always_comb begin
    case (r_state)
      S_PUNCH: w_state_nxt = (r_cnt == 4'd0) ? S_COOL : S_PUNCH;
      S_COOL:  w_state_nxt = (r_cnt == 4'd0) ? S_IDLE : S_COOL;
      S_JUMP:  w_state_nxt = w_land ? S_IDLE : S_JUMP;
`ifdef RYU_CROUCH_EN
      default: w_state_nxt = w_jump_edge ? S_JUMP : w_punch_edge ? S_PUNCH : w_down ? S_CROUCH : S_IDLE;
`else
      default: w_state_nxt = w_jump_edge ? S_JUMP : w_punch_edge ? S_PUNCH : S_IDLE;
`endif
    endcase
  end

  // Next sprite, position, velocity and frame counter for the current state.
  always_comb begin
    w_sprite_nxt = r_sprite;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_vy_nxt     = r_vy;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_PUNCH: begin
        w_sprite_nxt = (r_cnt == 4'd0) ? 3'd0 : 3'd1;
        w_cnt_nxt    = (r_cnt == 4'd0) ? C_COOL : r_cnt - 4'd1;
      end
      S_COOL: begin
        w_sprite_nxt = 3'd0;
        w_x_nxt      = w_x_walk;
        w_cnt_nxt    = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
      end
      S_JUMP: begin
        w_sprite_nxt = w_land ? 3'd0 : 3'd2;
        w_x_nxt      = w_x_walk;
        w_y_nxt      = w_land ? 10'(C_GROUND) : w_y_air;
        w_vy_nxt     = w_land ? 11'sd0 : r_vy - C_GRAV;
      end
      default: begin
        w_sprite_nxt = w_jump_edge ? 3'd2 : w_punch_edge ? 3'd1 : w_down ? 3'd3 : 3'd0;
        w_x_nxt      = (w_jump_edge | w_punch_edge | w_down | (r_state != S_IDLE)) ? r_x : w_x_walk;
        w_y_nxt      = w_jump_edge ? r_y - 10'(JUMP_V0) : r_y;
        w_vy_nxt     = w_jump_edge ? C_V0 - C_GRAV : r_vy;
        w_cnt_nxt    = (!w_jump_edge && w_punch_edge) ? C_PUNCH : r_cnt;
      end
    endcase
  end

  // Registered datapath and button history, all frozen between frame ticks.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sprite     <= 3'd0;
      r_x          <= 10'(X_START);
      r_y          <= 10'(GROUND_Y);
      r_vy         <= 11'sd0;
      r_cnt        <= 4'd0;
      r_punch_prev <= 1'b0;
      r_jump_prev  <= 1'b0;
    end else if (bus.frame_tick) begin
      r_sprite     <= w_sprite_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_vy         <= w_vy_nxt;
      r_cnt        <= w_cnt_nxt;
      r_punch_prev <= bus.punch_btn;
      r_jump_prev  <= bus.jump_btn;
    end
  end

  assign bus.sprite = r_sprite;
  assign bus.RyuX   = r_x;
  assign bus.RyuY   = r_y;
  assign bus.busy   = r_state != S_IDLE;
endmodule
